mult_share_arbiter: RTL

Round-robin arbiter/sequencer that shares one 8x8 start/done multiplier among NREQ requesters. It captures the winning requester's operands and drives the multiplier's start/done handshake to completion. It returns the 16-bit product tagged with the requester ID, and aborts with an error if the multiplier does not answer within a bounded time. It sits between the requesting datapath blocks and the single multiplier instance.

---
 rtl/mult_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin sequencer that shares one 8x8 start/done multiplier
//            among NREQ requesters. It captures the winner's operands, runs the
//            multiplier handshake and returns the 16-bit product tagged with
//            the requester ID. If the multiplier does not answer in time, the
//            operation is aborted and reported with an error.
// Ports    : clock, reset_n        - clock / async active-low reset
//            req, op_a, op_b       - per-requester request and packed operands
//            gnt                   - one-cycle one-hot operand-capture pulse
//            rsp_valid/id/product/err - one-cycle tagged response
//            busy                  - high whenever not IDLE
//            mul_start/a/b, mul_product/done - multiplier handshake
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] op_a,
  input  logic [8*NREQ-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_product,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_product,
  input  logic              mul_done
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;
  logic [TW-1:0]   timer;
  logic [15:0]     prod;
  logic            err;

  // Winner search: first set req bit starting at ptr, wrapping modulo NREQ.
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  win_next;
  logic [7:0]      win_a;
  logic [7:0]      win_b;

  always_comb begin
    found = 1'b0;
    win   = '0;
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IDW'(j);
        win_a = op_a[8*j +: 8];
        win_b = op_b[8*j +: 8];
      end
    end
    win_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cur_id      <= '0;
      timer       <= '0;
      prod        <= '0;
      err         <= 1'b0;
      gnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      // Pulse outputs default low; they are raised for exactly one cycle.
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            mul_a     <= win_a;
            mul_b     <= win_b;
            gnt       <= NREQ'(1) << win;
            mul_start <= 1'b1;
            cur_id    <= win;
            timer     <= '0;
            ptr       <= win_next;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A done on the same edge as timer expiry wins.
          if (mul_done) begin
            prod      <= mul_product;
            err       <= 1'b0;
            mul_start <= 1'b0;
            timer     <= '0;
            state     <= DRAIN;
          end else if (timer == TMAX) begin
            prod      <= '0;
            err       <= 1'b1;
            mul_start <= 1'b0;
            timer     <= '0;
            state     <= DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRAIN: begin
          // Wait for the multiplier to drop done so it is idle for the next
          // operation; a stuck done is bounded and reported as an error.
          if (!mul_done) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_product <= prod;
            rsp_err     <= err;
            state       <= RESP;
          end else if (timer == TMAX) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
